// File: rtl/data_memory_ctrl_pkg.sv
// Shared definitions for the data/instruction memory controller:
// access-size encodings, handshake FSM states, read/write polarity and
// small helpers for alignment, byte-enable generation and extension.
package data_memory_ctrl_pkg;

  // Access size encodings carried on the Size bus
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // RW polarity, shared with the control unit
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Handshake FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Reserved size, or low address bits not aligned to the access size
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte-lane enables; lane 3 is the addressed byte (big-endian, bits 31:24)
  function automatic logic [3:0] lane_enables(input logic [1:0] size);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b1000;
      SZ_HALF: be = 4'b1100;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Move the low-order write data into the high lanes that map to Address
  function automatic logic [31:0] lane_align(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      SZ_BYTE: lanes = {data[7:0], 24'h000000};
      SZ_HALF: lanes = {data[15:0], 16'h0000};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

  // Pick the addressed bytes from the 4-byte read and sign/zero extend them
  function automatic logic [31:0] extend_read(input logic [1:0] size, input logic se,
                                              input logic [31:0] raw);
    logic [31:0] ext;
    case (size)
      SZ_BYTE: ext = {{24{se & raw[31]}}, raw[31:24]};
      SZ_HALF: ext = {{16{se & raw[31]}}, raw[31:16]};
      default: ext = raw;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/data_memory_ctrl_mem_array.sv
// 256x8 storage array: byte-enable write of up to four consecutive bytes
// and an asynchronous 4-byte big-endian read starting at addr.
// Contents are deliberately not reset.
module mem_array_256x8
  import data_memory_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] a0_s;
  logic [ADDR_W-1:0] a1_s;
  logic [ADDR_W-1:0] a2_s;
  logic [ADDR_W-1:0] a3_s;

  assign a0_s = addr;
  assign a1_s = addr + ADDR_W'(1);
  assign a2_s = addr + ADDR_W'(2);
  assign a3_s = addr + ADDR_W'(3);

  // Byte-lane write; lane 3 lands at addr, lane 0 at addr+3
  always_ff @(posedge clk) begin
    if (we) begin
      if (be[3]) mem[a0_s] <= wdata[31:24];
      if (be[2]) mem[a1_s] <= wdata[23:16];
      if (be[1]) mem[a2_s] <= wdata[15:8];
      if (be[0]) mem[a3_s] <= wdata[7:0];
    end
  end

  // Combinational big-endian read of four bytes from addr
  always_comb begin
    rdata = {mem[a0_s], mem[a1_s], mem[a2_s], mem[a3_s]};
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressable data/instruction RAM with MOV/MFC handshake and
// programmable wait states. A request is latched on accept, held in BUSY
// for WAIT_CYCLES edges, performed on the next edge, then MFC stays high
// until the requester drops MOV.
module data_memory_ctrl
  import data_memory_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        Size,
  input  logic              SE,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MFC,
  output logic              MERR
);

  logic [1:0]        state_r;
  logic [3:0]        cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic              rw_r;
  logic [1:0]        size_r;
  logic              se_r;
  logic [31:0]       wdata_r;
  logic [31:0]       dout_r;
  logic              mfc_r;
  logic              merr_r;

  logic              err_s;
  logic              access_s;
  logic              mem_we_s;
  logic [3:0]        mem_be_s;
  logic [31:0]       mem_wdata_s;
  logic [31:0]       mem_rdata_s;
  logic [31:0]       rd_ext_s;

  // Access edge decode: BUSY, requester still waiting, wait states exhausted
  always_comb begin
    err_s       = is_misaligned(size_r, addr_r[1:0]);
    access_s    = (state_r == ST_BUSY) && MOV && (cnt_r == 4'd0);
    mem_we_s    = access_s && (rw_r == RW_WRITE) && !err_s;
    mem_be_s    = lane_enables(size_r);
    mem_wdata_s = lane_align(size_r, wdata_r);
    rd_ext_s    = extend_read(size_r, se_r, mem_rdata_s);
  end

  mem_array_256x8 #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (CLK),
    .we    (mem_we_s),
    .be    (mem_be_s),
    .addr  (addr_r),
    .wdata (mem_wdata_s),
    .rdata (mem_rdata_s)
  );

  // Handshake FSM with request latch and registered outputs
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= '0;
      rw_r    <= RW_READ;
      size_r  <= SZ_BYTE;
      se_r    <= 1'b0;
      wdata_r <= 32'h0000_0000;
      dout_r  <= 32'h0000_0000;
      mfc_r   <= 1'b0;
      merr_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (MOV) begin
            addr_r  <= Address;
            rw_r    <= RW;
            size_r  <= Size;
            se_r    <= SE;
            wdata_r <= DataIn;
            cnt_r   <= 4'(WAIT_CYCLES);
            state_r <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!MOV) begin
            // Requester gave up: nothing written, outputs left as they were
            state_r <= ST_IDLE;
          end else if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r <= ST_DONE;
            mfc_r   <= 1'b1;
            merr_r  <= err_s;
            if (!err_s && (rw_r == RW_READ)) begin
              dout_r <= rd_ext_s;
            end
          end
        end
        ST_DONE: begin
          if (!MOV) begin
            state_r <= ST_IDLE;
            mfc_r   <= 1'b0;
            merr_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          mfc_r   <= 1'b0;
          merr_r  <= 1'b0;
        end
      endcase
    end
  end

  assign DataOut = dout_r;
  assign MFC     = mfc_r;
  assign MERR    = merr_r;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: word/sub-word writes and reads,
// extension, misalignment, abort, hold and asynchronous reset.
module tb_data_memory_ctrl;

  localparam int WAIT   = 2;
  localparam int ADDR_W = 8;

  logic              CLK;
  logic              RSTn;
  logic              MOV;
  logic              RW;
  logic [1:0]        Size;
  logic              SE;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       DataIn;
  logic [31:0]       DataOut;
  logic              MFC;
  logic              MERR;

  int checks;
  int failures;

  logic [31:0] dout;
  logic        merr;
  int          lat;

  data_memory_ctrl #(
    .WAIT_CYCLES (WAIT),
    .DEPTH       (256),
    .ADDR_W      (ADDR_W)
  ) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .MOV     (MOV),
    .RW      (RW),
    .Size    (Size),
    .SE      (SE),
    .Address (Address),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .MFC     (MFC),
    .MERR    (MERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction; inputs are scrambled after accept to prove they were latched
  task automatic xfer(input logic rw, input logic [1:0] sz, input logic se,
                      input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] dout_o, output logic merr_o, output int lat_o);
    @(negedge CLK);
    MOV = 1'b1; RW = rw; Size = sz; SE = se; Address = a; DataIn = d;
    @(posedge CLK); #1;
    RW = ~rw; Size = ~sz; SE = ~se; Address = 8'hFF; DataIn = ~d;
    lat_o = 0;
    while (!MFC && lat_o < 20) begin
      @(posedge CLK); #1;
      lat_o++;
    end
    if (!MFC) check_eq("mfc_timeout", 32'(MFC), 32'd1);
    dout_o = DataOut;
    merr_o = MERR;
    @(negedge CLK);
    MOV = 1'b0;
    @(posedge CLK); #1;
    check_eq("mfc_clear", 32'(MFC), 32'd0);
    check_eq("merr_clear", 32'(MERR), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    MOV = 1'b0; RW = 1'b1; Size = 2'b00; SE = 1'b0; Address = 8'h00; DataIn = 32'h0;
    RSTn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_mfc", 32'(MFC), 32'd0);
    check_eq("rst_merr", 32'(MERR), 32'd0);
    check_eq("rst_dout", DataOut, 32'h0);
    @(negedge CLK); RSTn = 1'b1;

    // Word write then read
    xfer(1'b0, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, dout, merr, lat);
    check_eq("wr_lat", 32'(lat), 32'(WAIT + 1));
    check_eq("wr_merr", 32'(merr), 32'd0);
    check_eq("wr_dout_unchanged", dout, 32'h0);
    xfer(1'b1, 2'b10, 1'b0, 8'h10, 32'h0, dout, merr, lat);
    check_eq("rd_word", dout, 32'hDEADBEEF);
    check_eq("rd_word_merr", 32'(merr), 32'd0);
    check_eq("rd_lat", 32'(lat), 32'(WAIT + 1));

    // Byte and halfword extension
    xfer(1'b1, 2'b00, 1'b1, 8'h10, 32'h0, dout, merr, lat);
    check_eq("rd_byte_se", dout, 32'hFFFFFFDE);
    xfer(1'b1, 2'b00, 1'b0, 8'h10, 32'h0, dout, merr, lat);
    check_eq("rd_byte_ze", dout, 32'h000000DE);
    xfer(1'b1, 2'b01, 1'b1, 8'h12, 32'h0, dout, merr, lat);
    check_eq("rd_half_se", dout, 32'hFFFFBEEF);
    xfer(1'b1, 2'b01, 1'b0, 8'h10, 32'h0, dout, merr, lat);
    check_eq("rd_half_ze", dout, 32'h0000DEAD);
    xfer(1'b1, 2'b00, 1'b1, 8'h13, 32'h0, dout, merr, lat);
    check_eq("rd_byte_pos_se", dout, 32'hFFFFFFEF);

    // Sub-word write
    xfer(1'b0, 2'b00, 1'b0, 8'h11, 32'hAABBCC55, dout, merr, lat);
    check_eq("wr_byte_merr", 32'(merr), 32'd0);
    xfer(1'b1, 2'b10, 1'b0, 8'h10, 32'h0, dout, merr, lat);
    check_eq("rd_after_byte", dout, 32'hDE55BEEF);

    // Misaligned and reserved accesses
    xfer(1'b0, 2'b10, 1'b0, 8'h11, 32'hFFFFFFFF, dout, merr, lat);
    check_eq("mis_word_merr", 32'(merr), 32'd1);
    check_eq("mis_word_dout", dout, 32'hDE55BEEF);
    check_eq("mis_lat", 32'(lat), 32'(WAIT + 1));
    xfer(1'b1, 2'b10, 1'b0, 8'h10, 32'h0, dout, merr, lat);
    check_eq("rd_after_mis", dout, 32'hDE55BEEF);
    xfer(1'b1, 2'b11, 1'b0, 8'h10, 32'h0, dout, merr, lat);
    check_eq("rsvd_merr", 32'(merr), 32'd1);
    check_eq("rsvd_dout", dout, 32'hDE55BEEF);
    xfer(1'b0, 2'b01, 1'b0, 8'h13, 32'h00001234, dout, merr, lat);
    check_eq("mis_half_merr", 32'(merr), 32'd1);
    xfer(1'b1, 2'b10, 1'b0, 8'h10, 32'h0, dout, merr, lat);
    check_eq("rd_after_mis_half", dout, 32'hDE55BEEF);

    // Abort in first BUSY cycle
    xfer(1'b0, 2'b10, 1'b0, 8'h20, 32'h01020304, dout, merr, lat);
    @(negedge CLK);
    MOV = 1'b1; RW = 1'b0; Size = 2'b10; Address = 8'h20; DataIn = 32'h12345678;
    @(negedge CLK);
    MOV = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check_eq("abort_mfc", 32'(MFC), 32'd0);
    xfer(1'b1, 2'b10, 1'b0, 8'h20, 32'h0, dout, merr, lat);
    check_eq("abort_no_write", dout, 32'h01020304);

    // Handshake hold: MFC stays high, no second access
    @(negedge CLK);
    MOV = 1'b1; RW = 1'b1; Size = 2'b10; SE = 1'b0; Address = 8'h10;
    @(posedge CLK); #1;
    Address = 8'h20;
    lat = 0;
    while (!MFC && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
    end
    check_eq("hold_first", DataOut, 32'hDE55BEEF);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      check_eq("hold_mfc", 32'(MFC), 32'd1);
      check_eq("hold_dout", DataOut, 32'hDE55BEEF);
    end
    @(negedge CLK); MOV = 1'b0;
    @(posedge CLK); #1;
    check_eq("hold_drop_mfc", 32'(MFC), 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    check_eq("hold_no_reassert", 32'(MFC), 32'd0);

    // Asynchronous reset while in DONE
    @(negedge CLK);
    MOV = 1'b1; RW = 1'b1; Size = 2'b10; Address = 8'h10;
    lat = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
    end while (!MFC && lat < 20);
    check_eq("pre_rst_mfc", 32'(MFC), 32'd1);
    #2;
    RSTn = 1'b0;
    #1;
    check_eq("async_rst_mfc", 32'(MFC), 32'd0);
    check_eq("async_rst_dout", DataOut, 32'h0);
    MOV = 1'b0;
    @(negedge CLK); RSTn = 1'b1;

    // Reset during BUSY abandons the pending write
    @(negedge CLK);
    MOV = 1'b1; RW = 1'b0; Size = 2'b10; Address = 8'h20; DataIn = 32'hCAFEF00D;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RSTn = 1'b0; MOV = 1'b0;
    @(negedge CLK); RSTn = 1'b1;
    xfer(1'b1, 2'b10, 1'b0, 8'h20, 32'h0, dout, merr, lat);
    check_eq("rst_busy_no_write", dout, 32'h01020304);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
